// File: rtl/mat_vec_seq.sv
// rtl/mat_vec_seq.sv - load/compute/drain sequencer for the DIMxDIM matrix-vector datapath
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   start             begin a job (sampled only while idle)
//   busy, done        job in progress (CLEAR..DONE) / one-cycle completion pulse
//   row_valid/ready   matrix row handshake, row_data element j at [j*DATA_WIDTH +: DATA_WIDTH]
//   vec_valid/ready   vector element handshake, vec_data
//   clr               datapath accumulator clear, active low
//   a_wren, a_fifo_in registered row write into the DIM A FIFOs
//   b_wren, b_fifo_in registered element write into the B FIFO
//   a_rden, b_rden    skewed read enables for the compute phase
module mat_vec_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 8,
  parameter int MAC_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic                      row_valid,
  output logic                      row_ready,
  input  logic [DIM*DATA_WIDTH-1:0] row_data,
  input  logic                      vec_valid,
  output logic                      vec_ready,
  input  logic [DATA_WIDTH-1:0]     vec_data,
  output logic                      clr,
  output logic                      a_wren,
  output logic [DIM*DATA_WIDTH-1:0] a_fifo_in,
  output logic                      b_wren,
  output logic [DATA_WIDTH-1:0]     b_fifo_in,
  output logic [DIM-1:0]            a_rden,
  output logic                      b_rden
);

  // One shared counter serves loads, compute time t and drain; it is
  // cleared on every state change, so it must cover the longest phase.
  localparam int CW = $clog2(2*DIM + MAC_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_A, S_LOAD_B, S_GAP, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          row_hs, vec_hs;

  assign row_hs = row_valid && (state == S_LOAD_A);
  assign vec_hs = vec_valid && (state == S_LOAD_B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    busy      = 1'b1;
    done      = 1'b0;
    clr       = 1'b1;
    row_ready = 1'b0;
    vec_ready = 1'b0;
    b_rden    = 1'b0;
    a_rden    = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clr     = 1'b0;
        cnt_d   = '0;
        state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        row_ready = 1'b1;
        if (row_hs) begin
          if (cnt == CW'(DIM-1)) begin
            state_d = S_LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      S_LOAD_B: begin
        vec_ready = 1'b1;
        if (vec_hs) begin
          if (cnt == CW'(DIM-1)) begin
            state_d = S_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      S_GAP: begin
        // last registered b_wren lands this cycle; no reads yet
        state_d = S_COMPUTE;
        cnt_d   = '0;
      end
      S_COMPUTE: begin
        b_rden = (cnt < CW'(DIM));
        // FIFO k starts k cycles late so its column meets the right vector element
        for (int k = 0; k < DIM; k++) begin
          a_rden[k] = (cnt >= CW'(k)) && (cnt < CW'(k + DIM));
        end
        if (cnt == CW'(2*DIM-2)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == CW'(MAC_LAT-1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Write side is registered: a handshake in cycle n writes in cycle n+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_wren    <= 1'b0;
      a_fifo_in <= '0;
      b_wren    <= 1'b0;
      b_fifo_in <= '0;
    end else begin
      a_wren <= row_hs;
      b_wren <= vec_hs;
      if (row_hs) a_fifo_in <= row_data;
      if (vec_hs) b_fifo_in <= vec_data;
    end
  end

endmodule
